ps2_key_buffer: RTL and testbench
=================================

// Module: ps2_key_buffer
// PURPOSE
// - Downstream of ps2_keyboard. Takes raw PS/2 set-2 scan bytes (decoded_key/read_key) and tracks make/break/extended prefixes and shift/caps state.
// - Translates make codes to ASCII and queues the characters in a show-ahead FIFO. The CPU-side memory controller pops them one at a time.
// PARAMETERS
// - DEPTH   16  FIFO entries; must be a power of two, >= 2.
// - ADDR_W   4  log2(DEPTH).
// PORTS
// - clk          in   1         global clock (50MHz); the only clock.
// - rst          in   1         asynchronous, active-low reset.
// - key_code     in   8         scan byte from ps2_keyboard; stable while key_valid is high.
// - key_valid    in   1         byte-ready level or strobe from ps2_keyboard; may be asynchronous to clk.
// - ascii_read   in   1         one-cycle pop request from the CPU side.
// - overflow_clr in   1         clears the overflow flag.
// - ascii_out    out  8         FIFO head character; valid only while ascii_valid=1.
// - ascii_valid  out  1         FIFO non-empty.
// - fifo_count   out  ADDR_W+1  number of entries currently held (0..DEPTH).
// - overflow     out  1         sticky: a character was dropped because the FIFO was full.
// - shift_held   out  1         left or right shift is currently down.
// - caps_lock    out  1         caps-lock toggle state.
// BEHAVIOUR
// - Reset (rst=0, async): FIFO empty, pointers=0, ascii_out=8'h00, ascii_valid=0, fifo_count=0, overflow=0, shift_held=0, caps_lock=0, decoder state=IDLE.
// - Input capture: key_valid passes through a 2-flop synchroniser, then a rising-edge detect.
//   - key_code is registered on the detected edge. One scan byte is taken per rising edge; a high level held longer is not re-taken.
// - Decoder FSM (advances only on a captured byte):
//   - IDLE: F0->BRK; E0->EXT; 12/59->shift_held=1; 58->toggle caps_lock; other codes -> translate and push if the table maps them.
//   - BRK: 12/59->shift_held=0; any other byte ignored; ->IDLE.
//   - EXT: F0->EXT_BRK; any other byte ignored (no extended-key ASCII); ->IDLE.
//   - EXT_BRK: byte ignored; ->IDLE.
// - Translation table (make code -> ASCII), combinational:
//   - Letters 1C..: a-z, uppercase when shift_held XOR caps_lock.
//   - Digits 45,16,1E,26,25,2E,36,3D,3E,46 -> '0'-'9'; shift gives ")!@#$%^&*(".
//   - 29->20 space; 5A->0D enter; 66->08 backspace; 0D->09 tab; 76->1B escape.
//   - 4E,55,54,5B,4C,52,0E,41,49,4A,5D: -=[];'`,./\ and their shifted forms.
//   - All other codes: no push.
// - Latency: with the FIFO empty, ascii_valid rises on the 4th clk rising edge after key_valid is first sampled high (2 sync + 1 edge/decode + 1 write).
// - FIFO: show-ahead. ascii_out always reflects the head entry; ascii_read pops on the clk edge where it is sampled high.
//   - ascii_read while empty: ignored; count stays 0; no underflow.
//   - Push while full with no pop: character dropped, overflow<=1, count stays DEPTH.
//   - Push and pop in the same cycle: both happen, count unchanged. Valid when full (no drop) and when empty with no head (pop ignored, push accepted).
//   - Pointers are ADDR_W bits and wrap modulo DEPTH. fifo_count is the registered occupancy.
// - overflow_clr clears overflow. If overflow_clr and a dropping push occur in the same cycle, set wins.
// - Mid-operation reset aborts the FSM and discards all queued data immediately (async). The first byte taken after reset deasserts is decoded from IDLE.
// TESTING
// - Reset/idle: hold rst=0, then release -> all outputs 0; ascii_read pulses leave fifo_count=0 and ascii_valid=0.
// - Basic make/break: bytes 1C, F0, 1C -> exactly one entry 8'h61 ('a').
//   - ascii_valid rises 4 clks after the first key_valid; break produces no push.
// - Shift/caps: 12, 1C, F0, 12, 58, 1C, 12, 1C:
//   - FIFO = 41 ('A'), 41 ('A'), 61 ('a').
//   - caps_lock=1 and shift_held=1 at the end.
// - Extended/unknown: E0, 75, E0, F0, 75, then 07 -> no pushes; FSM back in IDLE; next 45 pushes 30 ('0').
// - Full/overflow: push DEPTH+1 'a' with no pops -> fifo_count=16, overflow=1, 16 entries of 61.
//   - Push + pop in the same cycle while full -> count stays 16, overflow unchanged.
//   - overflow_clr -> overflow=0.
// - Wrap and mid-op reset:
//   - 20 push/pop cycles; head order preserved across pointer wrap.
//   - Pulse rst=0 after F0 with 3 entries queued -> empty.
//   - Next 1C pushes 61 (not treated as break).

Source files
------------

// File: rtl/ps2_key_buffer_if.sv
// Scan-byte input and ASCII FIFO output bundle for ps2_key_buffer.
// master = keyboard/CPU side driving requests, slave = the buffer itself.
interface ps2_key_buffer_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]      key_code;
  logic            key_valid;
  logic            ascii_read;
  logic            overflow_clr;
  logic [7:0]      ascii_out;
  logic            ascii_valid;
  logic [ADDR_W:0] fifo_count;
  logic            overflow;
  logic            shift_held;
  logic            caps_lock;

  modport master (
    output key_code, key_valid, ascii_read, overflow_clr,
    input  ascii_out, ascii_valid, fifo_count, overflow, shift_held, caps_lock
  );

  modport slave (
    input  key_code, key_valid, ascii_read, overflow_clr,
    output ascii_out, ascii_valid, fifo_count, overflow, shift_held, caps_lock
  );
endinterface

// File: rtl/ps2_key_buffer.sv
// PS/2 set-2 scan byte decoder (make/break/extended, shift/caps) feeding a
// show-ahead ASCII FIFO that the CPU side pops one character at a time.
module ps2_key_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic             clk,
  input logic             rst,
  ps2_key_buffer_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} state_t;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [2:0]        sync_reg;
  logic [7:0]        byte_reg;
  logic              byte_stb_reg;
  logic              shift_reg;
  logic              caps_reg;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              overflow_reg;

  logic       hit;
  logic       letter;
  logic [7:0] lower;
  logic [7:0] upper;
  logic [7:0] mapped;
  logic       push;
  logic       pop;
  logic       full;
  logic       wr_en;
  logic       drop;

  // sync_reg[1:0] is the two-flop synchroniser; sync_reg[2] is the edge-detect history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg     <= 3'b000;
      byte_reg     <= 8'h00;
      byte_stb_reg <= 1'b0;
    end else begin
      sync_reg     <= {sync_reg[1:0], bus.key_valid};
      byte_stb_reg <= sync_reg[1] & ~sync_reg[2];
      if (sync_reg[1] & ~sync_reg[2]) begin
        byte_reg <= bus.key_code;
      end
    end
  end

  always_comb begin
    hit    = 1'b0;
    letter = 1'b0;
    lower  = 8'h00;
    upper  = 8'h00;
    case (byte_reg)
      8'h1C: begin hit = 1'b1; letter = 1'b1; lower = 8'h61; end
      8'h32: begin hit = 1'b1; letter = 1'b1; lower = 8'h62; end
      8'h21: begin hit = 1'b1; letter = 1'b1; lower = 8'h63; end
      8'h23: begin hit = 1'b1; letter = 1'b1; lower = 8'h64; end
      8'h24: begin hit = 1'b1; letter = 1'b1; lower = 8'h65; end
      8'h2B: begin hit = 1'b1; letter = 1'b1; lower = 8'h66; end
      8'h34: begin hit = 1'b1; letter = 1'b1; lower = 8'h67; end
      8'h33: begin hit = 1'b1; letter = 1'b1; lower = 8'h68; end
      8'h43: begin hit = 1'b1; letter = 1'b1; lower = 8'h69; end
      8'h3B: begin hit = 1'b1; letter = 1'b1; lower = 8'h6A; end
      8'h42: begin hit = 1'b1; letter = 1'b1; lower = 8'h6B; end
      8'h4B: begin hit = 1'b1; letter = 1'b1; lower = 8'h6C; end
      8'h3A: begin hit = 1'b1; letter = 1'b1; lower = 8'h6D; end
      8'h31: begin hit = 1'b1; letter = 1'b1; lower = 8'h6E; end
      8'h44: begin hit = 1'b1; letter = 1'b1; lower = 8'h6F; end
      8'h4D: begin hit = 1'b1; letter = 1'b1; lower = 8'h70; end
      8'h15: begin hit = 1'b1; letter = 1'b1; lower = 8'h71; end
      8'h2D: begin hit = 1'b1; letter = 1'b1; lower = 8'h72; end
      8'h1B: begin hit = 1'b1; letter = 1'b1; lower = 8'h73; end
      8'h2C: begin hit = 1'b1; letter = 1'b1; lower = 8'h74; end
      8'h3C: begin hit = 1'b1; letter = 1'b1; lower = 8'h75; end
      8'h2A: begin hit = 1'b1; letter = 1'b1; lower = 8'h76; end
      8'h1D: begin hit = 1'b1; letter = 1'b1; lower = 8'h77; end
      8'h22: begin hit = 1'b1; letter = 1'b1; lower = 8'h78; end
      8'h35: begin hit = 1'b1; letter = 1'b1; lower = 8'h79; end
      8'h1A: begin hit = 1'b1; letter = 1'b1; lower = 8'h7A; end
      8'h45: begin hit = 1'b1; lower = 8'h30; upper = 8'h29; end
      8'h16: begin hit = 1'b1; lower = 8'h31; upper = 8'h21; end
      8'h1E: begin hit = 1'b1; lower = 8'h32; upper = 8'h40; end
      8'h26: begin hit = 1'b1; lower = 8'h33; upper = 8'h23; end
      8'h25: begin hit = 1'b1; lower = 8'h34; upper = 8'h24; end
      8'h2E: begin hit = 1'b1; lower = 8'h35; upper = 8'h25; end
      8'h36: begin hit = 1'b1; lower = 8'h36; upper = 8'h5E; end
      8'h3D: begin hit = 1'b1; lower = 8'h37; upper = 8'h26; end
      8'h3E: begin hit = 1'b1; lower = 8'h38; upper = 8'h2A; end
      8'h46: begin hit = 1'b1; lower = 8'h39; upper = 8'h28; end
      8'h29: begin hit = 1'b1; lower = 8'h20; upper = 8'h20; end
      8'h5A: begin hit = 1'b1; lower = 8'h0D; upper = 8'h0D; end
      8'h66: begin hit = 1'b1; lower = 8'h08; upper = 8'h08; end
      8'h0D: begin hit = 1'b1; lower = 8'h09; upper = 8'h09; end
      8'h76: begin hit = 1'b1; lower = 8'h1B; upper = 8'h1B; end
      8'h4E: begin hit = 1'b1; lower = 8'h2D; upper = 8'h5F; end
      8'h55: begin hit = 1'b1; lower = 8'h3D; upper = 8'h2B; end
      8'h54: begin hit = 1'b1; lower = 8'h5B; upper = 8'h7B; end
      8'h5B: begin hit = 1'b1; lower = 8'h5D; upper = 8'h7D; end
      8'h4C: begin hit = 1'b1; lower = 8'h3B; upper = 8'h3A; end
      8'h52: begin hit = 1'b1; lower = 8'h27; upper = 8'h22; end
      8'h0E: begin hit = 1'b1; lower = 8'h60; upper = 8'h7E; end
      8'h41: begin hit = 1'b1; lower = 8'h2C; upper = 8'h3C; end
      8'h49: begin hit = 1'b1; lower = 8'h2E; upper = 8'h3E; end
      8'h4A: begin hit = 1'b1; lower = 8'h2F; upper = 8'h3F; end
      8'h5D: begin hit = 1'b1; lower = 8'h5C; upper = 8'h7C; end
      default: ;
    endcase
    if (letter) begin
      upper = lower ^ 8'h20;
    end
    // Caps lock only affects letters; digits and punctuation follow shift alone.
    if (letter) begin
      mapped = (shift_reg ^ caps_reg) ? upper : lower;
    end else begin
      mapped = shift_reg ? upper : lower;
    end
  end

  assign push  = byte_stb_reg && (state == ST_IDLE) && hit;
  assign pop   = bus.ascii_read && (count_reg != '0);
  assign full  = (count_reg == FULL_COUNT);
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      shift_reg <= 1'b0;
      caps_reg  <= 1'b0;
    end else if (byte_stb_reg) begin
      case (state)
        ST_IDLE: begin
          case (byte_reg)
            8'hF0:        state <= ST_BRK;
            8'hE0:        state <= ST_EXT;
            8'h12, 8'h59: shift_reg <= 1'b1;
            8'h58:        caps_reg <= ~caps_reg;
            default: ;
          endcase
        end
        ST_BRK: begin
          if (byte_reg == 8'h12 || byte_reg == 8'h59) begin
            shift_reg <= 1'b0;
          end
          state <= ST_IDLE;
        end
        ST_EXT:     state <= (byte_reg == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
        ST_EXT_BRK: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (bus.overflow_clr) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= mapped;
    end
  end

  assign bus.ascii_out   = (count_reg != '0) ? mem[rd_ptr_reg] : 8'h00;
  assign bus.ascii_valid = (count_reg != '0);
  assign bus.fifo_count  = count_reg;
  assign bus.overflow    = overflow_reg;
  assign bus.shift_held  = shift_reg;
  assign bus.caps_lock   = caps_reg;
endmodule

// File: tb/tb_ps2_key_buffer.sv
// Directed bench for ps2_key_buffer: decoding, shift/caps, FIFO full/wrap,
// overflow handling and asynchronous mid-operation reset.
module tb_ps2_key_buffer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] digit_codes [10];
  logic [7:0] digit_ascii [10];

  ps2_key_buffer_if #(.ADDR_W(4)) bus ();

  ps2_key_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one scan byte with a 2-cycle key_valid pulse and let it settle.
  task automatic send_byte(input logic [7:0] code);
    @(negedge clk);
    bus.key_code  = code;
    bus.key_valid = 1'b1;
    repeat (2) @(negedge clk);
    bus.key_valid = 1'b0;
    repeat (4) @(negedge clk);
    $display("byte %02h -> count %0d head %02h shift %0b caps %0b", code,
             bus.fifo_count, bus.ascii_out, bus.shift_held, bus.caps_lock);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check({tag, "_valid"}, 16'(bus.ascii_valid), 16'h1);
    check({tag, "_head"}, 16'(bus.ascii_out), 16'(exp));
    $display("pop %s head %02h", tag, bus.ascii_out);
    bus.ascii_read = 1'b1;
    @(negedge clk);
    bus.ascii_read = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    digit_codes = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    digit_ascii = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    rst = 1'b0;
    bus.key_code = 8'h00;
    bus.key_valid = 1'b0;
    bus.ascii_read = 1'b0;
    bus.overflow_clr = 1'b0;

    // Reset and idle pops
    repeat (3) @(negedge clk);
    check("rst_valid", 16'(bus.ascii_valid), 16'h0);
    check("rst_out", 16'(bus.ascii_out), 16'h00);
    check("rst_count", 16'(bus.fifo_count), 16'h0);
    check("rst_overflow", 16'(bus.overflow), 16'h0);
    check("rst_shift", 16'(bus.shift_held), 16'h0);
    check("rst_caps", 16'(bus.caps_lock), 16'h0);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      bus.ascii_read = 1'b1;
      @(negedge clk);
      bus.ascii_read = 1'b0;
    end
    check("idle_pop_count", 16'(bus.fifo_count), 16'h0);
    check("idle_pop_valid", 16'(bus.ascii_valid), 16'h0);
    $display("reset/idle done");

    // Latency: valid appears on the 4th rising edge after key_valid is sampled
    @(negedge clk);
    bus.key_code  = 8'h1C;
    bus.key_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("lat_edge3", 16'(bus.ascii_valid), 16'h0);
    @(posedge clk);
    #1 check("lat_edge4", 16'(bus.ascii_valid), 16'h1);
    @(negedge clk);
    bus.key_valid = 1'b0;
    repeat (4) @(negedge clk);
    $display("byte 1c (latency) -> count %0d", bus.fifo_count);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("mb_count", 16'(bus.fifo_count), 16'h1);
    pop_expect("mb_a", 8'h61);
    check("mb_empty", 16'(bus.fifo_count), 16'h0);

    // Shift / caps
    send_byte(8'h12);
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h12);
    send_byte(8'h58);
    send_byte(8'h1C);
    send_byte(8'h12);
    send_byte(8'h1C);
    check("sc_caps", 16'(bus.caps_lock), 16'h1);
    check("sc_shift", 16'(bus.shift_held), 16'h1);
    check("sc_count", 16'(bus.fifo_count), 16'h3);
    pop_expect("sc_0", 8'h41);
    pop_expect("sc_1", 8'h41);
    pop_expect("sc_2", 8'h61);
    send_byte(8'h16);
    pop_expect("sc_bang", 8'h21);
    send_byte(8'hF0);
    send_byte(8'h59);
    send_byte(8'h58);
    check("sc_shift_off", 16'(bus.shift_held), 16'h0);
    check("sc_caps_off", 16'(bus.caps_lock), 16'h0);
    send_byte(8'h4A);
    pop_expect("sc_slash", 8'h2F);

    // Extended and unknown codes
    send_byte(8'hE0);
    send_byte(8'h75);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    send_byte(8'h07);
    check("ext_count", 16'(bus.fifo_count), 16'h0);
    send_byte(8'h45);
    check("ext_idle_count", 16'(bus.fifo_count), 16'h1);
    pop_expect("ext_zero", 8'h30);
    send_byte(8'h29);
    pop_expect("space", 8'h20);

    // Full / overflow
    for (int i = 0; i < 17; i++) send_byte(8'h1C);
    check("full_count", 16'(bus.fifo_count), 16'd16);
    check("full_overflow", 16'(bus.overflow), 16'h1);
    // Push 'b' on exactly the cycle the pop is sampled
    @(negedge clk);
    bus.key_code  = 8'h32;
    bus.key_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.key_valid  = 1'b0;
    bus.ascii_read = 1'b1;
    @(negedge clk);
    bus.ascii_read = 1'b0;
    $display("push b + pop while full -> count %0d", bus.fifo_count);
    check("pp_full_count", 16'(bus.fifo_count), 16'd16);
    check("pp_full_overflow", 16'(bus.overflow), 16'h1);
    @(negedge clk);
    bus.overflow_clr = 1'b1;
    @(negedge clk);
    bus.overflow_clr = 1'b0;
    check("ovf_clr", 16'(bus.overflow), 16'h0);
    for (int i = 0; i < 15; i++) pop_expect("full_a", 8'h61);
    pop_expect("full_b", 8'h62);
    check("full_drain", 16'(bus.fifo_count), 16'h0);

    // Wrap: push/pop through the pointer boundary
    for (int i = 0; i < 20; i++) begin
      send_byte(digit_codes[i % 10]);
      pop_expect("wrap", digit_ascii[i % 10]);
    end
    check("wrap_count", 16'(bus.fifo_count), 16'h0);

    // Mid-operation asynchronous reset
    send_byte(8'h1C);
    send_byte(8'h32);
    send_byte(8'h21);
    send_byte(8'hF0);
    check("pre_rst_count", 16'(bus.fifo_count), 16'h3);
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("async_rst_count", 16'(bus.fifo_count), 16'h0);
    check("async_rst_valid", 16'(bus.ascii_valid), 16'h0);
    @(negedge clk);
    rst = 1'b1;
    send_byte(8'h1C);
    check("post_rst_count", 16'(bus.fifo_count), 16'h1);
    pop_expect("post_rst_a", 8'h61);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
